// File: rtl/packet_pkg.sv
// Shared sizes and types for the 4-port switch datapath and its output scheduler.
package packet_pkg;

    localparam int DEF_NUM_PORTS   = 4;
    localparam int DEF_HOLD_CYCLES = 3;
    localparam int DEF_SEL_W       = $clog2(DEF_NUM_PORTS);
    localparam int CNT_W           = 4;

    typedef logic [DEF_NUM_PORTS-1:0] port_mask_t;
    typedef logic [DEF_SEL_W-1:0]     port_idx_t;
    typedef logic [CNT_W-1:0]         hold_cnt_t;

    typedef enum logic {
        OUT_IDLE,
        OUT_HELD
    } out_state_e;

endpackage

// File: rtl/out_hold_ctr.sv
// Per-output ownership tracker: hold counter, owning input index and the
// free / still-held flags the allocator consults.
module out_hold_ctr
    import packet_pkg::*;
#(
    parameter int SEL_W       = DEF_SEL_W,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [SEL_W-1:0] src,
    output logic [SEL_W-1:0] mux_sel,
    output logic             active,
    output logic             free,
    output logic             held_long
);

    localparam hold_cnt_t HOLD_VAL = hold_cnt_t'(HOLD_CYCLES);
    localparam hold_cnt_t CNT_ONE  = hold_cnt_t'(1);

    out_state_e       state;
    out_state_e       state_nxt;
    hold_cnt_t        cnt;
    hold_cnt_t        cnt_nxt;
    logic [SEL_W-1:0] sel_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= OUT_IDLE;
            cnt     <= '0;
            mux_sel <= '0;
            active  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            mux_sel <= sel_nxt;
            active  <= (cnt_nxt != '0);
        end
    end

    // A load while HELD only happens on the last cycle, giving bubble-free handover.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sel_nxt   = mux_sel;
        case (state)
            OUT_IDLE: begin
                if (load) begin
                    state_nxt = OUT_HELD;
                    cnt_nxt   = HOLD_VAL;
                    sel_nxt   = src;
                end
            end
            OUT_HELD: begin
                if (load) begin
                    cnt_nxt = HOLD_VAL;
                    sel_nxt = src;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state_nxt = OUT_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = OUT_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign free      = (state == OUT_IDLE) || (cnt == CNT_ONE);
    assign held_long = (state == OUT_HELD) && (cnt > CNT_ONE);

endmodule

// File: rtl/switch_scheduler.sv
// Output-port scheduler: rotating-priority all-or-nothing allocation of
// output ports to input destination masks, with a fixed per-grant hold time.
module switch_scheduler
    import packet_pkg::*;
#(
    parameter int NUM_PORTS   = DEF_NUM_PORTS,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int SEL_W       = $clog2(NUM_PORTS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] port0_dst,
    input  logic [NUM_PORTS-1:0] port1_dst,
    input  logic [NUM_PORTS-1:0] port2_dst,
    input  logic [NUM_PORTS-1:0] port3_dst,
    output logic [NUM_PORTS-1:0] grant_bus,
    output logic [SEL_W-1:0]     mux_sel0,
    output logic [SEL_W-1:0]     mux_sel1,
    output logic [SEL_W-1:0]     mux_sel2,
    output logic [SEL_W-1:0]     mux_sel3,
    output logic                 active0,
    output logic                 active1,
    output logic                 active2,
    output logic                 active3,
    output logic                 busy
);

    logic [NUM_PORTS-1:0] dst [NUM_PORTS];
    logic [SEL_W-1:0]     sel [NUM_PORTS];
    logic [SEL_W-1:0]     load_src_p0 [NUM_PORTS];
    logic [NUM_PORTS-1:0] load_vec_p0;
    logic [NUM_PORTS-1:0] grant_p0;
    logic [NUM_PORTS-1:0] claimed;
    logic [NUM_PORTS-1:0] out_free;
    logic [NUM_PORTS-1:0] out_long;
    logic [NUM_PORTS-1:0] out_active;
    logic [NUM_PORTS-1:0] in_busy;
    logic [SEL_W-1:0]     ptr;
    logic [SEL_W-1:0]     first_idx;
    logic [SEL_W-1:0]     cand;
    logic                 any_grant;

    assign dst[0] = port0_dst;
    assign dst[1] = port1_dst;
    assign dst[2] = port2_dst;
    assign dst[3] = port3_dst;

    // An input still mid-packet on some output may not start another one.
    always_comb begin
        in_busy = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (out_long[k]) begin
                in_busy[sel[k]] = 1'b1;
            end
        end
    end

    always_comb begin
        grant_p0  = '0;
        claimed   = '0;
        any_grant = 1'b0;
        first_idx = ptr;
        cand      = ptr;
        for (int off = 0; off < NUM_PORTS; off++) begin
            cand = SEL_W'((int'(ptr) + off) % NUM_PORTS);
            if ((dst[cand] != '0) && !in_busy[cand] &&
                ((dst[cand] & ~(out_free & ~claimed)) == '0)) begin
                grant_p0[cand] = 1'b1;
                claimed        = claimed | dst[cand];
                if (!any_grant) begin
                    first_idx = cand;
                    any_grant = 1'b1;
                end
            end
        end
    end

    always_comb begin
        load_vec_p0 = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            load_src_p0[k] = '0;
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (grant_p0[i] && dst[i][k]) begin
                    load_vec_p0[k] = 1'b1;
                    load_src_p0[k] = SEL_W'(i);
                end
            end
        end
    end

    // p0 -> p1: allocation result registered onto the grant bus and pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_bus <= '0;
            ptr       <= '0;
        end else begin
            grant_bus <= grant_p0;
            if (any_grant) begin
                ptr <= SEL_W'((int'(first_idx) + 1) % NUM_PORTS);
            end
        end
    end

    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_out
        out_hold_ctr #(
            .SEL_W       (SEL_W),
            .HOLD_CYCLES (HOLD_CYCLES)
        ) u_ctr (
            .clk       (clk),
            .rst       (rst),
            .load      (load_vec_p0[k]),
            .src       (load_src_p0[k]),
            .mux_sel   (sel[k]),
            .active    (out_active[k]),
            .free      (out_free[k]),
            .held_long (out_long[k])
        );
    end

    assign mux_sel0 = sel[0];
    assign mux_sel1 = sel[1];
    assign mux_sel2 = sel[2];
    assign mux_sel3 = sel[3];
    assign active0  = out_active[0];
    assign active1  = out_active[1];
    assign active2  = out_active[2];
    assign active3  = out_active[3];
    assign busy     = |out_active;

endmodule

// File: tb/tb_switch_scheduler.sv
// Directed bench for switch_scheduler with hand-computed expectations.
module tb_switch_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] port0_dst = '0;
    logic [3:0] port1_dst = '0;
    logic [3:0] port2_dst = '0;
    logic [3:0] port3_dst = '0;
    logic [3:0] grant_bus;
    logic [1:0] mux_sel0, mux_sel1, mux_sel2, mux_sel3;
    logic       active0, active1, active2, active3;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    switch_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .port0_dst (port0_dst),
        .port1_dst (port1_dst),
        .port2_dst (port2_dst),
        .port3_dst (port3_dst),
        .grant_bus (grant_bus),
        .mux_sel0  (mux_sel0),
        .mux_sel1  (mux_sel1),
        .mux_sel2  (mux_sel2),
        .mux_sel3  (mux_sel3),
        .active0   (active0),
        .active1   (active1),
        .active2   (active2),
        .active3   (active3),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_dst();
        port0_dst = '0;
        port1_dst = '0;
        port2_dst = '0;
        port3_dst = '0;
    endtask

    task automatic do_reset();
        clear_dst();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // reset, idle
        do_reset();
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("idle_grant", 32'(grant_bus), 32'h0);
            chk("idle_active", 32'({active3, active2, active1, active0}), 32'h0);
            chk("idle_busy", 32'(busy), 32'h0);
            chk("idle_sel", 32'({mux_sel3, mux_sel2, mux_sel1, mux_sel0}), 32'h0);
        end

        // unicast input 1 -> output 2, one-cycle request
        port1_dst = 4'b0100;
        tick();
        port1_dst = '0;
        chk("uc_grant", 32'(grant_bus), 32'h2);
        chk("uc_sel2", 32'(mux_sel2), 32'h1);
        chk("uc_act2_c1", 32'(active2), 32'h1);
        chk("uc_busy", 32'(busy), 32'h1);
        tick();
        chk("uc_pulse", 32'(grant_bus), 32'h0);
        chk("uc_act2_c2", 32'(active2), 32'h1);
        tick();
        chk("uc_act2_c3", 32'(active2), 32'h1);
        tick();
        chk("uc_act2_off", 32'(active2), 32'h0);
        chk("uc_busy_off", 32'(busy), 32'h0);

        // ptr now 2: inputs 1 and 2 contend for output 0, input 2 wins
        port1_dst = 4'b0001;
        port2_dst = 4'b0001;
        tick();
        clear_dst();
        chk("ptr_grant", 32'(grant_bus), 32'h4);
        chk("ptr_sel0", 32'(mux_sel0), 32'h2);

        // reset mid-hold
        rst = 1'b1;
        tick();
        chk("rst_hold_active", 32'({active3, active2, active1, active0}), 32'h0);
        chk("rst_hold_busy", 32'(busy), 32'h0);
        chk("rst_hold_grant", 32'(grant_bus), 32'h0);
        rst = 1'b0;
        do_reset();

        // all inputs want output 0 continuously: rotation every 3 cycles
        port0_dst = 4'b0001;
        port1_dst = 4'b0001;
        port2_dst = 4'b0001;
        port3_dst = 4'b0001;
        for (int c = 1; c <= 13; c++) begin
            tick();
            if ((c - 1) % 3 == 0) begin
                chk("rot_grant", 32'(grant_bus), 32'(1 << (((c - 1) / 3) % 4)));
                chk("rot_sel0", 32'(mux_sel0), 32'(((c - 1) / 3) % 4));
            end else begin
                chk("rot_nogrant", 32'(grant_bus), 32'h0);
            end
            chk("rot_act0", 32'(active0), 32'h1);
        end
        do_reset();

        // disjoint multicasts granted together
        port0_dst = 4'b0011;
        port1_dst = 4'b1100;
        tick();
        clear_dst();
        chk("mc_grant", 32'(grant_bus), 32'h3);
        chk("mc_sels", 32'({mux_sel3, mux_sel2, mux_sel1, mux_sel0}), 32'b01010000);
        chk("mc_active", 32'({active3, active2, active1, active0}), 32'hF);
        do_reset();

        // no partial multicast while output 1 is held by input 3
        port3_dst = 4'b0010;
        tick();
        port3_dst = '0;
        chk("part_g3", 32'(grant_bus), 32'h8);
        chk("part_sel1", 32'(mux_sel1), 32'h3);
        port0_dst = 4'b0011;
        tick();
        chk("part_wait1_grant", 32'(grant_bus), 32'h0);
        chk("part_wait1_act0", 32'(active0), 32'h0);
        chk("part_wait1_act1", 32'(active1), 32'h1);
        tick();
        chk("part_wait2_grant", 32'(grant_bus), 32'h0);
        chk("part_wait2_act0", 32'(active0), 32'h0);
        tick();
        port0_dst = '0;
        chk("part_grant", 32'(grant_bus), 32'h1);
        chk("part_act", 32'({active1, active0}), 32'h3);
        chk("part_sels", 32'({mux_sel1, mux_sel0}), 32'h0);
        do_reset();

        // busy input: input 2 owns output 0, its next packet waits for the last cycle
        port2_dst = 4'b0001;
        tick();
        chk("bz_first", 32'(grant_bus), 32'h4);
        port2_dst = 4'b1000;
        tick();
        chk("bz_wait1", 32'(grant_bus), 32'h0);
        chk("bz_wait1_act3", 32'(active3), 32'h0);
        tick();
        chk("bz_wait2", 32'(grant_bus), 32'h0);
        chk("bz_last_act0", 32'(active0), 32'h1);
        tick();
        port2_dst = '0;
        chk("bz_grant", 32'(grant_bus), 32'h4);
        chk("bz_act3", 32'(active3), 32'h1);
        chk("bz_sel3", 32'(mux_sel3), 32'h2);
        chk("bz_act0_off", 32'(active0), 32'h0);
        chk("bz_busy", 32'(busy), 32'h1);

        // loopback mask is legal
        do_reset();
        port2_dst = 4'b0100;
        tick();
        clear_dst();
        chk("loop_grant", 32'(grant_bus), 32'h4);
        chk("loop_sel2", 32'(mux_sel2), 32'h2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
